fb_access_arbiter: RTL and testbench

Single-clock arbiter that shares one single-port frame-buffer RAM (2-bit pixels, 160x144 = 23040 words) between two requesters: the Game Boy pixel writer and the VGA line reader. Reads have priority. Writes are buffered in a small FIFO, and a starvation counter guarantees that buffered writes drain. This block replaces per-buffer clock muxing, so the whole frame-buffer path runs on `clock`.

---
 rtl/fb_access_if.sv | 48 ++++
 rtl/fb_access_arbiter.sv | 131 +++++++++++++
 tb/tb_fb_access_arbiter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_access_if.sv
// Bundle of requester, RAM and status signals around the frame-buffer arbiter.
// The slave modport is the arbiter's view; master is the surrounding logic's view.
interface fb_access_if #(
    parameter int ADDR_W      = 15,
    parameter int DATA_W      = 2,
    parameter int WFIFO_DEPTH = 4
);
    localparam int LVL_W = $clog2(WFIFO_DEPTH) + 1;

    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_gnt;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;

    logic [LVL_W-1:0]  wr_level;
    logic              wr_drop;

    modport slave (
        input  wr_valid, wr_addr, wr_data,
        output wr_ready,
        input  rd_req, rd_addr,
        output rd_gnt, rd_valid, rd_data,
        output ram_addr, ram_we, ram_din,
        input  ram_dout,
        output wr_level, wr_drop
    );

    modport master (
        output wr_valid, wr_addr, wr_data,
        input  wr_ready,
        output rd_req, rd_addr,
        input  rd_gnt, rd_valid, rd_data,
        input  ram_addr, ram_we, ram_din,
        output ram_dout,
        input  wr_level, wr_drop
    );
endinterface

// File: rtl/fb_access_arbiter.sv
// Shares one single-port frame-buffer RAM between the pixel writer and the line reader.
// Reads win by default; a buffered write is forced after MAX_WR_WAIT cycles of starvation.
module fb_access_arbiter #(
    parameter int ADDR_W      = 15,
    parameter int DATA_W      = 2,
    parameter int WFIFO_DEPTH = 4,   // power of 2, at least 2
    parameter int MAX_WR_WAIT = 8
) (
    input logic       clock,
    input logic       reset,
    fb_access_if.slave bus
);
    localparam int PTR_W = $clog2(WFIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(MAX_WR_WAIT + 1);

    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(WFIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_WR_WAIT);

    typedef enum logic [1:0] {
        GNT_IDLE,
        GNT_READ,
        GNT_WRITE
    } grant_t;

    logic [ADDR_W-1:0] fifo_addr [WFIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [WFIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level;
    logic [CNT_W-1:0]  wait_cnt;
    logic              rd_valid_q;
    logic              wr_drop_q;

    logic              fifo_nonempty;
    logic              fifo_full;
    logic              force_wr;
    logic              push;
    logic              pop;
    grant_t            grant;

    assign fifo_nonempty = (level != '0);
    assign fifo_full     = (level == LVL_FULL);
    assign force_wr      = fifo_nonempty && (wait_cnt == CNT_MAX);

    // wr_ready looks only at the registered level, never at a same-cycle pop
    assign push = bus.wr_valid && !fifo_full;
    assign pop  = (grant == GNT_WRITE);

    always_comb begin
        grant = GNT_IDLE;
        if (bus.rd_req && !force_wr) begin
            grant = GNT_READ;
        end else if (fifo_nonempty) begin
            grant = GNT_WRITE;
        end
    end

    always_comb begin
        bus.ram_addr = bus.rd_addr;
        bus.ram_din  = fifo_data[rd_ptr];
        bus.ram_we   = 1'b0;
        bus.rd_gnt   = 1'b0;
        case (grant)
            GNT_READ: begin
                bus.rd_gnt = 1'b1;
            end
            GNT_WRITE: begin
                bus.ram_addr = fifo_addr[rd_ptr];
                bus.ram_we   = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.wr_ready = !fifo_full;
    assign bus.wr_level = level;
    assign bus.wr_drop  = wr_drop_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = bus.ram_dout;

    // Storage needs no reset; only pointers and level define what is valid.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_addr[wr_ptr] <= bus.wr_addr;
            fifo_data[wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (pop || !fifo_nonempty) begin
            wait_cnt <= '0;
        end else if (wait_cnt != CNT_MAX) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            wr_drop_q  <= 1'b0;
        end else begin
            rd_valid_q <= bus.rd_gnt;
            if (bus.wr_valid && fifo_full) begin
                wr_drop_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fb_access_arbiter.sv
// Directed bench for fb_access_arbiter with a behavioural single-port RAM.
module tb_fb_access_arbiter;
    logic clock = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clock = ~clock;

    fb_access_if #(.ADDR_W(15), .DATA_W(2), .WFIFO_DEPTH(4)) bus ();

    fb_access_arbiter #(
        .ADDR_W(15), .DATA_W(2), .WFIFO_DEPTH(4), .MAX_WR_WAIT(8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    logic [1:0] mem [0:32767];

    always @(posedge clock) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
        bus.ram_dout <= mem[bus.ram_addr];
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs;
        bus.wr_valid = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.rd_req   = 1'b0;
        bus.rd_addr  = '0;
    endtask

    initial begin
        int k;
        logic exp_we;
        for (int i = 0; i < 32768; i++) mem[i] = 2'b00;
        mem[100]     = 2'b10;
        bus.ram_dout = 2'b00;
        idle_inputs();

        // reset with random inputs
        reset        = 1'b1;
        bus.wr_valid = 1'($urandom);
        bus.wr_addr  = 15'($urandom);
        bus.wr_data  = 2'($urandom);
        bus.rd_req   = 1'($urandom);
        bus.rd_addr  = 15'($urandom);
        tick();
        bus.wr_valid = 1'($urandom);
        bus.wr_addr  = 15'($urandom);
        bus.rd_req   = 1'($urandom);
        bus.rd_addr  = 15'($urandom);
        #2;
        chk("rst_hold_ram_we", 32'(bus.ram_we), 0);
        tick();
        reset = 1'b0;
        idle_inputs();
        #2;
        chk("rst_wr_ready", 32'(bus.wr_ready), 1);
        chk("rst_wr_level", 32'(bus.wr_level), 0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 0);
        chk("rst_wr_drop",  32'(bus.wr_drop),  0);
        chk("rst_ram_we",   32'(bus.ram_we),   0);
        chk("rst_rd_gnt",   32'(bus.rd_gnt),   0);

        // write only: pushes at N..N+2, RAM writes at N+1..N+3
        bus.wr_valid = 1'b1; bus.wr_addr = 15'd0; bus.wr_data = 2'd3;
        #2;
        chk("wo_no_bypass", 32'(bus.ram_we), 0);
        tick();
        bus.wr_addr = 15'd1; bus.wr_data = 2'd2;
        #2;
        chk("wo1_we",    32'(bus.ram_we),   1);
        chk("wo1_addr",  32'(bus.ram_addr), 0);
        chk("wo1_din",   32'(bus.ram_din),  3);
        chk("wo1_level", 32'(bus.wr_level), 1);
        tick();
        bus.wr_addr = 15'd2; bus.wr_data = 2'd1;
        #2;
        chk("wo2_we",    32'(bus.ram_we),   1);
        chk("wo2_addr",  32'(bus.ram_addr), 1);
        chk("wo2_din",   32'(bus.ram_din),  2);
        chk("wo2_level", 32'(bus.wr_level), 1);
        tick();
        bus.wr_valid = 1'b0;
        #2;
        chk("wo3_we",    32'(bus.ram_we),   1);
        chk("wo3_addr",  32'(bus.ram_addr), 2);
        chk("wo3_din",   32'(bus.ram_din),  1);
        chk("wo3_level", 32'(bus.wr_level), 1);
        tick();
        #2;
        chk("wo4_we",    32'(bus.ram_we),   0);
        chk("wo4_level", 32'(bus.wr_level), 0);

        // read latency
        bus.rd_req = 1'b1; bus.rd_addr = 15'd100;
        #2;
        chk("rl_gnt",  32'(bus.rd_gnt),   1);
        chk("rl_addr", 32'(bus.ram_addr), 100);
        chk("rl_we",   32'(bus.ram_we),   0);
        tick();
        bus.rd_req = 1'b0;
        #2;
        chk("rl_valid", 32'(bus.rd_valid), 1);
        chk("rl_data",  32'(bus.rd_data),  2);
        tick();
        #2;
        chk("rl_valid_drop", 32'(bus.rd_valid), 0);

        // starvation: one write behind a continuous read stream
        bus.rd_req = 1'b1; bus.rd_addr = 15'd200;
        bus.wr_valid = 1'b1; bus.wr_addr = 15'd5; bus.wr_data = 2'd1;
        #2;
        chk("st_push_gnt", 32'(bus.rd_gnt), 1);
        tick();
        bus.wr_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #2;
            chk("st_rd_gnt", 32'(bus.rd_gnt), 1);
            chk("st_no_we",  32'(bus.ram_we), 0);
            tick();
        end
        #2;
        chk("st_force_gnt",  32'(bus.rd_gnt),   0);
        chk("st_force_we",   32'(bus.ram_we),   1);
        chk("st_force_addr", 32'(bus.ram_addr), 5);
        chk("st_force_din",  32'(bus.ram_din),  1);
        tick();
        #2;
        chk("st_resume_gnt", 32'(bus.rd_gnt),   1);
        chk("st_resume_we",  32'(bus.ram_we),   0);
        chk("st_level",      32'(bus.wr_level), 0);
        chk("st_no_rvalid",  32'(bus.rd_valid), 0);
        tick();

        // overflow: five back-to-back pushes under read pressure
        for (int i = 0; i < 5; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_addr  = 15'(10 + i);
            bus.wr_data  = 2'(i);
            #2;
            chk("ov_wr_ready", 32'(bus.wr_ready), (i < 4) ? 1 : 0);
            tick();
        end
        bus.wr_valid = 1'b0;
        #2;
        chk("ov_drop",  32'(bus.wr_drop),  1);
        chk("ov_level", 32'(bus.wr_level), 4);
        k = 0;
        for (int c = 5; c <= 40; c++) begin
            #2;
            exp_we = (c == 9) || (c == 18) || (c == 27) || (c == 36);
            chk("ov_we", 32'(bus.ram_we), 32'(exp_we));
            if (exp_we) begin
                chk("ov_addr", 32'(bus.ram_addr), 32'(10 + k));
                chk("ov_din",  32'(bus.ram_din),  32'(k % 4));
                k++;
            end
            tick();
        end
        #2;
        chk("ov_drained",     32'(bus.wr_level), 0);
        chk("ov_drop_sticky", 32'(bus.wr_drop),  1);
        chk("ov_write_count", 32'(k),            4);

        // reset mid-operation: 3 queued writes and a read in flight
        bus.rd_addr = 15'd300;
        for (int i = 0; i < 3; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_addr  = 15'(20 + i);
            bus.wr_data  = 2'(i + 1);
            tick();
        end
        bus.wr_valid = 1'b0;
        #2;
        chk("rm_gnt",   32'(bus.rd_gnt),   1);
        chk("rm_level", 32'(bus.wr_level), 3);
        tick();
        reset = 1'b1;
        #2;
        chk("rm_inflight", 32'(bus.rd_valid), 1);
        tick();
        reset = 1'b0;
        bus.rd_req = 1'b0;
        #2;
        chk("rm_rd_valid", 32'(bus.rd_valid), 0);
        chk("rm_level",    32'(bus.wr_level), 0);
        chk("rm_drop_clr", 32'(bus.wr_drop),  0);
        chk("rm_ready",    32'(bus.wr_ready), 1);
        for (int i = 0; i < 3; i++) begin
            chk("rm_no_we", 32'(bus.ram_we), 0);
            tick();
            #2;
        end

        // full FIFO popped in the same cycle a push is offered
        bus.rd_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_addr  = 15'(40 + i);
            bus.wr_data  = 2'(i);
            tick();
        end
        bus.rd_req  = 1'b0;
        bus.wr_addr = 15'd50;
        bus.wr_data = 2'd3;
        #2;
        chk("fp_level", 32'(bus.wr_level), 4);
        chk("fp_ready", 32'(bus.wr_ready), 0);
        chk("fp_we",    32'(bus.ram_we),   1);
        chk("fp_addr",  32'(bus.ram_addr), 40);
        tick();
        bus.wr_valid = 1'b0;
        #2;
        chk("fp_level_after", 32'(bus.wr_level), 3);
        chk("fp_drop",        32'(bus.wr_drop),  1);
        chk("fp_next_addr",   32'(bus.ram_addr), 41);
        tick();
        tick();
        tick();
        #2;
        chk("fp_drained", 32'(bus.wr_level), 0);
        chk("fp_mem43",   32'(mem[43]),      3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
